// File: rtl/md5_candidate_gen_if.sv
// md5_candidate_gen_if: candidate block stream (valid/ready, padded block, candidate length)
interface md5_candidate_gen_if;
    logic         valid;
    logic         ready;
    logic [511:0] m_out;
    logic [5:0]   cand_len;
    modport master (output valid, m_out, cand_len, input ready);
    modport slave  (input valid, m_out, cand_len, output ready);
endinterface

// File: rtl/md5_candidate_gen.sv
// md5_candidate_gen: odometer brute-force source emitting MD5-padded blocks; MD5_GEN_SEED_EN adds a seeded start point
module md5_candidate_gen #(
    parameter logic [7:0] CHARSET_BASE = 8'h61,
    parameter int         CHARSET_SIZE = 26,
    parameter int         MAX_LEN      = 8,
    parameter int         COUNT_W      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef MD5_GEN_SEED_EN
    input  logic [5:0]           seed_len,
    input  logic [8*MAX_LEN-1:0] seed_digits,
`endif
    md5_candidate_gen_if.master  bus,
    output logic [COUNT_W-1:0]   cand_count,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] LAST    = 8'(CHARSET_SIZE - 1);
    localparam logic [5:0] TOP_LEN = 6'(MAX_LEN);
    state_t                   state, state_n;
    logic [MAX_LEN-1:0][7:0]  dig, dig_n, init_dig;
    logic [5:0]               len, len_n, init_len;
    logic [COUNT_W-1:0]       count_n;
    logic                     last, carry, load;

    function automatic logic [511:0] pad_block(input logic [5:0] l, input logic [MAX_LEN-1:0][7:0] d);
        logic [511:0] m;
        m = '0;
        for (int j = 0; j < MAX_LEN; j++)
            if (j < int'(l)) m[8*j +: 8] = CHARSET_BASE + d[j];
        m[8*l +: 8] = 8'h80;
        m[448 +: 64] = {55'b0, l, 3'b0};
        return m;
    endfunction

`ifdef MD5_GEN_SEED_EN
    // clamp the seed so every instance starts on a legal candidate
    always_comb begin
        init_len = (seed_len == 6'd0 || seed_len > TOP_LEN) ? 6'd1 : seed_len;
        init_dig = '0;
        for (int k = 0; k < MAX_LEN; k++)
            init_dig[k] = (k < int'(init_len) && int'(seed_digits[8*k +: 8]) < CHARSET_SIZE) ? seed_digits[8*k +: 8] : 8'd0;
    end
`else
    assign init_len = 6'd1;
    assign init_dig = '0;
`endif

    // last candidate: full length with every digit at the top character
    always_comb begin
        last = (len == TOP_LEN);
        for (int j = 0; j < MAX_LEN; j++) last = last && (dig[j] == LAST);
    end

    // next state, odometer advance and count update
    always_comb begin
        state_n = state;
        len_n   = len;
        dig_n   = dig;
        count_n = cand_count;
        load    = 1'b0;
        carry   = 1'b0;
        if (state != RUN) begin
            if (start) begin
                state_n = RUN;
                len_n   = init_len;
                dig_n   = init_dig;
                count_n = '0;
                load    = 1'b1;
            end
        end else if (bus.ready) begin
            count_n = cand_count + 1'b1;
            if (last) begin
                state_n = DONE;
            end else begin
                load  = 1'b1;
                carry = 1'b1;
                for (int j = 0; j < MAX_LEN; j++)
                    if (carry && j < int'(len)) begin
                        dig_n[j] = (dig[j] == LAST) ? 8'd0 : dig[j] + 8'd1;
                        carry    = (dig[j] == LAST);
                    end
                if (carry) begin
                    len_n = len + 6'd1;
                    dig_n = '0;
                end
            end
        end
    end

    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // odometer, counter and block register; the block is built from the next odometer value
    always_ff @(posedge clk)
        if (rst) begin
            dig        <= '0;
            len        <= '0;
            cand_count <= '0;
            bus.m_out  <= '0;
        end else begin
            dig        <= dig_n;
            len        <= len_n;
            cand_count <= count_n;
            if (load) bus.m_out <= pad_block(len_n, dig_n);
        end

    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign bus.valid    = busy;
    assign bus.cand_len = len;
endmodule

// File: doc/md5_candidate_gen.md
Name: md5_candidate_gen

Overview:
Brute-force candidate source at the head of the MD5 round pipeline. It enumerates every password over a contiguous character range for lengths 1..MAX_LEN. For each candidate it emits one fully MD5-padded 512-bit message block, at most one per cycle, into the first round stage's `m` input. Valid/ready flow control lets the pipeline front end hold off issue. A done flag marks an exhausted keyspace.

Parameters:
CHARSET_BASE, 8'h61, byte value of digit 0 ('a').
CHARSET_SIZE, 26, number of characters; digit d maps to byte CHARSET_BASE+d; legal range 2..256.
MAX_LEN, 8, longest candidate in bytes; legal range 1..55.
COUNT_W, 64, width of cand_count.

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; begins enumeration from IDLE or DONE.
ready  in  1  downstream accepts m_out this cycle.
m_out  out  512  padded MD5 block; 32-bit word i at m_out[32*i +: 32]; byte j at m_out[8*j +: 8].
valid  out  1  m_out holds a candidate.
cand_len  out  6  byte length of the current candidate.
cand_count  out  COUNT_W  candidates accepted (valid && ready) since the last start.
busy  out  1  high in RUN.
done  out  1  high in DONE.

Behaviour:
- Synchronous, active-high reset, taken on any cycle including mid-run. Reset values: state=IDLE, m_out=0, valid=0, cand_len=0, cand_count=0, busy=0, done=0, all digits=0.
- State is held as an odometer of MAX_LEN digit registers plus a length register. Digit 0 is byte 0 and increments fastest.
- IDLE: on start -> RUN with len=1 and all digits 0. The first candidate appears with valid=1 on the cycle after start. Latency from start to first valid is 1 cycle.
- RUN, with valid=1:
  - If ready=0, hold all outputs and state unchanged.
  - If ready=1 (accept):
    - cand_count += 1.
    - If the candidate is not the last in the space, advance the odometer. Digit 0 increments; a digit reaching CHARSET_SIZE wraps to 0 and carries into the next digit, up to digit len-1.
    - A carry out of digit len-1 gives len+1 with all digits 0.
    - The next candidate is visible on the following cycle, so throughput is 1 candidate per cycle under continuous ready.
- Last candidate: len==MAX_LEN and every digit == CHARSET_SIZE-1. When it is accepted, go to DONE: valid=0, done=1, busy=0. m_out and cand_len hold their last value. No wrap back to length 1.
- DONE: start -> RUN with the same initial conditions as from IDLE. cand_count clears to 0 on that start.
- start in RUN is ignored. start coincident with rst is ignored; reset wins.
- m_out construction, fully registered and recomputed from the next-state odometer:
  - bytes 0..len-1 = CHARSET_BASE + digit[j].
  - byte len = 8'h80.
  - bytes len+1..55 = 0.
  - m_out[448 +: 64] = len*8, little-endian 64-bit bit count.
  - Digits at index >= len never leak into m_out.
- Arithmetic: CHARSET_BASE+digit is 8 bits and wraps modulo 256. cand_count wraps silently at 2^COUNT_W.
- busy = (state==RUN), done = (state==DONE), valid = busy. All three are registered.

Optional Feature:
MD5_GEN_SEED_EN: when defined, two inputs are added.
- seed_len (6 bits) and seed_digits (8*MAX_LEN bits; byte k is the digit k index) are sampled on start. Enumeration begins at that candidate, so multiple instances can partition the keyspace.
- seed_len of 0 or greater than MAX_LEN is treated as 1.
- A seed digit >= CHARSET_SIZE is loaded as 0.
- Seed digits at index >= seed_len are loaded as 0.
Without the macro, these ports do not exist and start always begins at length 1 with all digits 0.

Test Plan:
1. Defaults, rst then start with ready=1 -> next cycle valid=1, cand_len=1, m_out[7:0]=8'h61, m_out[15:8]=8'h80, m_out[455:448]=8'h08, all other bits 0. The 27th accepted block has bytes 61 61 80, m_out[455:448]=8'h10, cand_len=2.
2. CHARSET_SIZE=3, MAX_LEN=2, ready=1 -> exactly 12 valid cycles in order a,b,c,aa,ba,ca,ab,...,cc. Then done=1, valid=0, cand_count=12, m_out holds "cc".
3. Backpressure: during RUN, hold ready=0 for 5 cycles -> m_out, cand_len and cand_count are frozen. On release, the next candidate follows in order with no skip or duplicate.
4. Reset mid-run after 10 accepts -> next cycle all outputs equal their reset values. A subsequent start restarts at "a" with cand_count=0.
5. Restart from DONE (config of test 2) -> start clears done and cand_count and re-emits "a". start pulsed during RUN has no effect on the sequence.
6. With MD5_GEN_SEED_EN: seed_len=2, seed_digits={8'h00,8'h19} -> first block "za" (7A 61 80). Next accept gives "ab". seed_len=0 -> first block "a".
